board_io_ctrl: RTL and testbench

//  Parametrised board front-end between raw DE2 pins and the MIPS system core.
//  - Synchronises and debounces N push-buttons; emits clean levels and one-cycle press pulses.
//  - Synchronises the switch bank.
//  - Generates a single-step pulse and a PC-load request/ack handshake.
//  - Registers the LED bus.

---
 rtl/board_io_pkg.sv | 15 +
 rtl/board_io_ctrl_key_debounce.sv | 94 +++++++++
 rtl/board_io_ctrl.sv | 107 ++++++++++
 tb/tb_board_io_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared types and constants for the DE2 board front-end.
package board_io_pkg;

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        CNT_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CNT_REL   = 2'd3
    } db_state_t;

    localparam int STEP_KEY          = 0;
    localparam int LOAD_KEY          = 1;
    localparam int DEFAULT_DB_CYCLES = 500000;

endpackage

// File: rtl/board_io_ctrl_key_debounce.sv
// One push-button: reset-to-released synchroniser, debounce FSM and saturating counter.
// DB_CYCLES must be >= 2.
module key_debounce
    import board_io_pkg::*;
#(
    parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_q, press_d;

    // Raw key is active-low; the chain resets to "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end

    assign pressed = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // The cycle in which the change is first seen in a stable state is count 0,
    // so a new state is accepted after exactly DB_CYCLES differing cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            RELEASED: if (pressed) begin
                state_d = CNT_PRESS;
                cnt_d   = CNT_ONE;
            end
            CNT_PRESS: begin
                if (!pressed) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: if (!pressed) begin
                state_d = CNT_REL;
                cnt_d   = CNT_ONE;
            end
            CNT_REL: begin
                if (pressed) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == PRESSED) || (state_q == CNT_REL);
    assign press = press_q;

endmodule

// File: rtl/board_io_ctrl.sv
// DE2 board front-end: key debounce, switch sync, step pulse, PC-load handshake, LED register.
// Optional free-running auto-step under BOARD_IO_AUTORUN_EN.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int SW_W        = 18,
    parameter int LED_W       = 8,
    parameter int PC_W        = 8,
    parameter int DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter int SYNC_STAGES = 2
`ifdef BOARD_IO_AUTORUN_EN
    ,
    parameter int AUTO_DIV    = 25000000
`endif
) (
    input  logic              SYS_clk,
    input  logic              SYS_rst,
    input  logic [N_KEYS-1:0] KEY_raw,
    input  logic [SW_W-1:0]   SW_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [SW_W-1:0]   sw_sync,
    output logic              step_pulse,
    output logic              pc_load_req,
    output logic [PC_W-1:0]   pc_load_val,
    input  logic              pc_load_ack,
    input  logic [LED_W-1:0]  led_src,
    output logic [LED_W-1:0]  SYS_leds
`ifdef BOARD_IO_AUTORUN_EN
    ,
    input  logic              run_en
`endif
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_db (
            .clk     (SYS_clk),
            .rst_n   (SYS_rst),
            .key_raw (KEY_raw[k]),
            .level   (key_level[k]),
            .press   (key_press[k])
        );
    end

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_q;

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) sw_q <= '0;
        else          sw_q <= {sw_q[SYNC_STAGES-2:0], SW_raw};
    end

    assign sw_sync = sw_q[SYNC_STAGES-1];

`ifdef BOARD_IO_AUTORUN_EN
    localparam int DIV_W = $clog2(AUTO_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

    logic [DIV_W-1:0] div_q;

    // Divider only runs while run_en is high; dropping run_en zeroes it silently.
    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            div_q      <= '0;
            step_pulse <= 1'b0;
        end else if (run_en) begin
            if (div_q == DIV_LAST) begin
                div_q      <= '0;
                step_pulse <= 1'b1;
            end else begin
                div_q      <= div_q + DIV_W'(1);
                step_pulse <= 1'b0;
            end
        end else begin
            div_q      <= '0;
            step_pulse <= key_press[STEP_KEY];
        end
    end
`else
    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) step_pulse <= 1'b0;
        else          step_pulse <= key_press[STEP_KEY];
    end
`endif

    // While a request is outstanding only ack matters; new LOAD presses are dropped.
    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            pc_load_req <= 1'b0;
            pc_load_val <= '0;
        end else if (pc_load_req) begin
            if (pc_load_ack) pc_load_req <= 1'b0;
        end else if (key_press[LOAD_KEY]) begin
            pc_load_req <= 1'b1;
            pc_load_val <= sw_sync[SW_W-1 -: PC_W];
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) SYS_leds <= '0;
        else          SYS_leds <= led_src;
    end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl with DB_CYCLES=4, SYNC_STAGES=2.
module tb_board_io_ctrl;

    localparam int N_KEYS = 4;
    localparam int SW_W   = 18;
    localparam int LED_W  = 8;
    localparam int PC_W   = 8;
    localparam int EV_PRESS = 0;
    localparam int EV_STEP  = 1;
    localparam int EV_REQ   = 2;

    logic              clk = 1'b0;
    logic              SYS_rst;
    logic [N_KEYS-1:0] KEY_raw;
    logic [SW_W-1:0]   SW_raw;
    logic [N_KEYS-1:0] key_level, key_press;
    logic [SW_W-1:0]   sw_sync;
    logic              step_pulse, pc_load_req, pc_load_ack;
    logic [PC_W-1:0]   pc_load_val;
    logic [LED_W-1:0]  led_src, SYS_leds;
    logic              run_en;

    typedef struct {
        int unsigned at;
        int          kind;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        req_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_io_ctrl #(
        .N_KEYS (N_KEYS), .SW_W (SW_W), .LED_W (LED_W), .PC_W (PC_W),
        .DB_CYCLES (4), .SYNC_STAGES (2)
`ifdef BOARD_IO_AUTORUN_EN
        , .AUTO_DIV (5)
`endif
    ) dut (
        .SYS_clk     (clk),
        .SYS_rst     (SYS_rst),
        .KEY_raw     (KEY_raw),
        .SW_raw      (SW_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .sw_sync     (sw_sync),
        .step_pulse  (step_pulse),
        .pc_load_req (pc_load_req),
        .pc_load_val (pc_load_val),
        .pc_load_ack (pc_load_ack),
        .led_src     (led_src),
        .SYS_leds    (SYS_leds)
`ifdef BOARD_IO_AUTORUN_EN
        , .run_en    (run_en)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_ev(input int kind, input int unsigned at, input logic [15:0] data);
        exp_t e;
        e.at = at; e.kind = kind; e.data = data;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [15:0] data);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%h want none", kind, cyc, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.at != cyc || e.data != data) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%h want kind=%0d cyc=%0d data=%h",
                         kind, cyc, data, e.kind, e.at, e.data);
            end
        end
    endtask

    // Monitor: every observable event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (SYS_rst) begin
            if (key_press != '0) observe(EV_PRESS, 16'(key_press));
            if (step_pulse)      observe(EV_STEP, 16'h0001);
            if (pc_load_req != req_prev)
                observe(EV_REQ, {7'd0, pc_load_req, (pc_load_req ? pc_load_val : 8'h00)});
        end
        req_prev <= pc_load_req;
    end

    // Hold a key low for 10 cycles, then release and let the release debounce settle.
    task automatic press_key(input int k);
        KEY_raw[k] = 1'b0;
        tick(10);
        KEY_raw[k] = 1'b1;
        tick(8);
    endtask

    initial begin
        int unsigned e0;
        SYS_rst = 1'b0; KEY_raw = '1; SW_raw = '0; led_src = 8'hFF;
        pc_load_ack = 1'b0; run_en = 1'b0;
        tick(3);
        chk("rst_key_level", 32'(key_level), 32'h0);
        chk("rst_sw_sync",   32'(sw_sync),   32'h0);
        chk("rst_req_val",   {23'd0, pc_load_req, pc_load_val}, 32'h0);
        chk("rst_step_leds", {23'd0, step_pulse, SYS_leds}, 32'h0);
        SYS_rst = 1'b1;

        // Switch sync and LED register latency
        SW_raw = 18'h2A5C3; led_src = 8'h5A;
        tick(1);
        chk("leds_lat1", 32'(SYS_leds), 32'h5A);
        chk("sw_sync_lat1", 32'(sw_sync), 32'h0);
        tick(1);
        chk("sw_sync_lat2", 32'(sw_sync), 32'h2A5C3);
        led_src = 8'hC3;
        tick(1);
        chk("leds_c3", 32'(SYS_leds), 32'hC3);

        // Clean press on the step key
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0001);
        expect_ev(EV_STEP,  e0 + 7, 16'h0001);
        KEY_raw[0] = 1'b0;
        tick(5);
        chk("level_before_6", 32'(key_level[0]), 32'h0);
        tick(1);
        chk("level_at_6", 32'(key_level[0]), 32'h1);
        tick(4);
        KEY_raw[0] = 1'b1;
        tick(8);
        chk("level_released", 32'(key_level[0]), 32'h0);

        // Bounce never reaches DB_CYCLES
        KEY_raw[0] = 1'b0; tick(1);
        KEY_raw[0] = 1'b1; tick(1);
        KEY_raw[0] = 1'b0; tick(1);
        KEY_raw[0] = 1'b1; tick(10);
        chk("bounce_level", 32'(key_level), 32'h0);

        // PC load: capture A5, ignore second press, clear on ack
        SW_raw = {8'hA5, 10'h0};
        tick(3);
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0002);
        expect_ev(EV_REQ,   e0 + 7, 16'h01A5);
        press_key(1);
        chk("load_req", {23'd0, pc_load_req, pc_load_val}, 32'h1A5);
        SW_raw = {8'h3C, 10'h0};
        tick(3);
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0002);
        press_key(1);
        chk("load_frozen", {23'd0, pc_load_req, pc_load_val}, 32'h1A5);
        pc_load_ack = 1'b1;
        expect_ev(EV_REQ, cyc + 1, 16'h0000);
        tick(1);
        pc_load_ack = 1'b0;
        tick(2);
        chk("ack_clears", 32'(pc_load_req), 32'h0);
        pc_load_ack = 1'b1;
        tick(2);
        pc_load_ack = 1'b0;
        tick(1);
        chk("ack_idle_ignored", 32'(pc_load_req), 32'h0);

        // New request, then ack coincident with a new LOAD press
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0002);
        expect_ev(EV_REQ,   e0 + 7, 16'h013C);
        press_key(1);
        chk("load_3c", {23'd0, pc_load_req, pc_load_val}, 32'h13C);
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0002);
        KEY_raw[1] = 1'b0;
        tick(6);
        pc_load_ack = 1'b1;
        expect_ev(EV_REQ, e0 + 7, 16'h0000);
        tick(1);
        pc_load_ack = 1'b0;
        tick(4);
        KEY_raw[1] = 1'b1;
        tick(8);
        chk("ack_beats_press", 32'(pc_load_req), 32'h0);

        // Async reset mid CNT_PRESS with a request outstanding
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0002);
        expect_ev(EV_REQ,   e0 + 7, 16'h013C);
        press_key(1);
        KEY_raw[0] = 1'b0;
        tick(4);
        #2 SYS_rst = 1'b0;
        #1;
        chk("mid_rst_req_val", {23'd0, pc_load_req, pc_load_val}, 32'h0);
        chk("mid_rst_key", {24'd0, key_level, key_press}, 32'h0);
        chk("mid_rst_misc", {5'd0, step_pulse, sw_sync, SYS_leds}, 32'h0);
        tick(2);
        SYS_rst = 1'b1;
        e0 = cyc;
        expect_ev(EV_PRESS, e0 + 6, 16'h0001);
        expect_ev(EV_STEP,  e0 + 7, 16'h0001);
        tick(5);
        chk("post_rst_before_6", 32'(key_level[0]), 32'h0);
        tick(1);
        chk("post_rst_at_6", 32'(key_level[0]), 32'h1);
        tick(4);
        KEY_raw[0] = 1'b1;
        tick(8);

`ifdef BOARD_IO_AUTORUN_EN
        // Auto-step every 5 cycles; a manual step press adds no pulse
        e0 = cyc;
        run_en = 1'b1;
        expect_ev(EV_STEP,  e0 + 5,  16'h0001);
        expect_ev(EV_PRESS, e0 + 8,  16'h0001);
        expect_ev(EV_STEP,  e0 + 10, 16'h0001);
        expect_ev(EV_STEP,  e0 + 15, 16'h0001);
        expect_ev(EV_STEP,  e0 + 20, 16'h0001);
        tick(2);
        KEY_raw[0] = 1'b0;
        tick(10);
        KEY_raw[0] = 1'b1;
        tick(8);
        run_en = 1'b0;
        tick(10);
`endif

        tick(5);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_event: got none want kind=%0d cyc=%0d data=%h", e.kind, e.at, e.data);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
